// File: rtl/muldiv_pkg.sv
// muldiv_pkg
// Shared definitions for the iterative multiply/divide unit.
//   - op_t      : operation encodings as presented on the 'op' port
//   - state_t   : sequencer states of the top level
//   - DEFAULT_WIDTH / CNT_W : default operand width and matching step-counter width
//   - cnt_width : counter width for an arbitrary WIDTH (ceil(log2(WIDTH)))
package muldiv_pkg;

    localparam int DEFAULT_WIDTH = 32;

    function automatic int cnt_width(input int w);
        return $clog2(w);
    endfunction

    localparam int CNT_W = cnt_width(DEFAULT_WIDTH);

    typedef enum logic [1:0] {
        OP_MULTU = 2'b00,
        OP_MULT  = 2'b01,
        OP_DIVU  = 2'b10,
        OP_DIV   = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10
    } state_t;

endpackage

// File: rtl/muldiv_iter.sv
// muldiv_iter
// Radix-2 datapath for the multiply/divide unit. Holds one 2*WIDTH-bit register
// that is the {HI,LO} product accumulator for multiplies and the
// {remainder,quotient} pair for divides, plus the held multiplicand/divisor.
// Operands arrive as unsigned magnitudes; sign handling lives in the top level.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : capture operands and initialise the accumulator
//   step       : perform one shift-add (multiply) or restoring-subtract (divide) step
//   is_div     : mode selected at load (1 = divide)
//   a_mag      : multiplicand / dividend magnitude
//   b_mag      : multiplier / divisor magnitude
//   acc        : accumulator, final result after WIDTH steps
module muldiv_iter
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic                 step,
    input  logic                 is_div,
    input  logic [WIDTH-1:0]     a_mag,
    input  logic [WIDTH-1:0]     b_mag,
    output logic [2*WIDTH-1:0]   acc
);

    logic [WIDTH-1:0]   opnd;
    logic               div_mode;
    logic [WIDTH-1:0]   addend;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     diff;
    logic [2*WIDTH-1:0] acc_nxt;

    // Multiply keeps the multiplier in the low half and retires one bit per step
    // from the right; the carry out of the add shifts back into the top.
    // Divide shifts the dividend out of the low half into the partial remainder
    // and shifts quotient bits in from the right.
    always_comb begin
        addend  = acc[0] ? opnd : '0;
        mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, addend};
        rem_sh  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        diff    = rem_sh - {1'b0, opnd};
        acc_nxt = acc;
        if (div_mode) begin
            if (!diff[WIDTH]) begin
                acc_nxt = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            end else begin
                acc_nxt = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_nxt = {mul_sum, acc[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            opnd     <= '0;
            div_mode <= 1'b0;
        end else if (load) begin
            acc      <= {{WIDTH{1'b0}}, (is_div ? a_mag : b_mag)};
            opnd     <= is_div ? b_mag : a_mag;
            div_mode <= is_div;
        end else if (step) begin
            acc      <= acc_nxt;
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit
// Iterative MULT/MULTU/DIV/DIVU unit with the architectural HI/LO registers.
// A request takes WIDTH+2 cycles (IDLE -> CALC x WIDTH -> FIX); the core stalls
// on busy. MFHI/MFLO read through the combinational rd_data port; MTHI/MTLO
// write through hilo_we while idle.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   start, op, a, b     : operation request (sampled only when idle)
//   hilo_we, hilo_wsel  : MTHI/MTLO write enable and select (1 = HI)
//   wdata               : MTHI/MTLO data
//   rd_sel, rd_data     : HI/LO read select (1 = HI) and read data
//   busy                : operation in progress
//   done                : one-cycle pulse, HI/LO hold the new result
// Optional build macro: MULDIV_FAST_MUL_EN -- MULT/MULTU complete in a single
// cycle without entering CALC; divides still use the iterative path.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hilo_we,
    input  logic             hilo_wsel,
    input  logic [WIDTH-1:0] wdata,
    input  logic             rd_sel,
    output logic [WIDTH-1:0] rd_data,
    output logic             busy,
    output logic             done
);

    localparam int             CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_t               state;
    state_t               state_nxt;
    logic [CW-1:0]        cnt;
    logic                 load;
    logic                 step;
    logic                 fix;
    logic                 fast_take;
    logic [2*WIDTH-1:0]   fast_prod;

    logic [WIDTH-1:0]     hi;
    logic [WIDTH-1:0]     lo;
    logic [WIDTH-1:0]     a_q;
    logic                 is_div_q;
    logic                 b_zero_q;
    logic                 q_neg_q;
    logic                 r_neg_q;

    logic                 signed_op;
    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;
    logic [2*WIDTH-1:0]   acc;
    logic [WIDTH-1:0]     res_hi;
    logic [WIDTH-1:0]     res_lo;

    assign signed_op = (op == OP_MULT) || (op == OP_DIV);
    assign a_mag     = (signed_op && a[WIDTH-1]) ? -a : a;
    assign b_mag     = (signed_op && b[WIDTH-1]) ? -b : b;

`ifdef MULDIV_FAST_MUL_EN
    logic [2*WIDTH-1:0] ext_a;
    logic [2*WIDTH-1:0] ext_b;

    // The low 2*WIDTH bits of a product of sign-extended operands equal the
    // signed product, so one multiplier serves both MULT and MULTU.
    assign ext_a     = {{WIDTH{signed_op & a[WIDTH-1]}}, a};
    assign ext_b     = {{WIDTH{signed_op & b[WIDTH-1]}}, b};
    assign fast_prod = ext_a * ext_b;
    assign fast_take = (state == IDLE) && start && !op[1];
`else
    assign fast_prod = '0;
    assign fast_take = 1'b0;
`endif

    muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (load),
        .step   (step),
        .is_div (op[1]),
        .a_mag  (a_mag),
        .b_mag  (b_mag),
        .acc    (acc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Sequencer: one load cycle from IDLE, WIDTH steps in CALC, then a single
    // FIX cycle that commits the result to HI/LO.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        fix       = 1'b0;
        case (state)
            IDLE: begin
                if (start && !fast_take) begin
                    load      = 1'b1;
                    state_nxt = CALC;
                end
            end
            CALC: begin
                step = 1'b1;
                if (cnt == LAST) begin
                    state_nxt = FIX;
                end
            end
            FIX: begin
                fix       = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= '0;
        end else if (step) begin
            cnt <= cnt + CW'(1);
        end
    end

    // Sign and zero-divisor information is captured with the operands so that
    // FIX does not depend on the live input ports.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            is_div_q <= 1'b0;
            b_zero_q <= 1'b0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
        end else if (load) begin
            a_q      <= a;
            is_div_q <= op[1];
            b_zero_q <= (b == '0);
            q_neg_q  <= signed_op && (a[WIDTH-1] ^ b[WIDTH-1]);
            r_neg_q  <= signed_op && a[WIDTH-1];
        end
    end

    // Sign correction. A zero divisor bypasses the datapath result entirely:
    // HI returns the dividend and LO is all ones.
    always_comb begin
        res_hi = acc[2*WIDTH-1:WIDTH];
        res_lo = acc[WIDTH-1:0];
        if (is_div_q) begin
            if (b_zero_q) begin
                res_hi = a_q;
                res_lo = '1;
            end else begin
                res_hi = r_neg_q ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
                res_lo = q_neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
            end
        end else if (q_neg_q) begin
            {res_hi, res_lo} = -acc;
        end
    end

    // HI/LO ownership: a committing result takes priority; direct writes are
    // honoured only while idle, which includes the cycle that samples start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi   <= '0;
            lo   <= '0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (fix) begin
                hi   <= res_hi;
                lo   <= res_lo;
                done <= 1'b1;
            end else if (fast_take) begin
                hi   <= fast_prod[2*WIDTH-1:WIDTH];
                lo   <= fast_prod[WIDTH-1:0];
                done <= 1'b1;
            end else if (hilo_we && (state == IDLE)) begin
                if (hilo_wsel) begin
                    hi <= wdata;
                end else begin
                    lo <= wdata;
                end
            end
        end
    end

    assign busy    = (state != IDLE);
    assign rd_data = rd_sel ? hi : lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit
// Self-checking bench for muldiv_unit (default build, WIDTH=32): vector table
// with expected HI/LO, scoreboard queue filled at start and drained on done,
// plus hand-written sequences for busy-time interactions and mid-operation reset.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int W   = 32;
    localparam int LAT = W + 2;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [1:0]    op;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          hilo_we;
    logic          hilo_wsel;
    logic [W-1:0]  wdata;
    logic          rd_sel;
    logic [W-1:0]  rd_data;
    logic          busy;
    logic          done;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          tag;
    } exp_t;

    exp_t sb_q[$];
    vec_t vecs[10];
    int   checks;
    int   errors;
    int   tag_cnt;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .hilo_we   (hilo_we),
        .hilo_wsel (hilo_wsel),
        .wdata     (wdata),
        .rd_sel    (rd_sel),
        .rd_data   (rd_data),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic readHiLo(output logic [31:0] h, output logic [31:0] l);
        rd_sel = 1'b1;
        #1 h = rd_data;
        rd_sel = 1'b0;
        #1 l = rd_data;
    endtask

    // Reference model built on plain SV arithmetic.
    task automatic model(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv,
                         output logic [31:0] eh, output logic [31:0] el);
        logic [63:0] p;
        longint      sa, sb, q, r;
        p  = '0;
        eh = '0;
        el = '0;
        if (o == OP_MULTU) begin
            p = {32'b0, av} * {32'b0, bv};
            {eh, el} = p;
        end else if (o == OP_MULT) begin
            p = $signed({{32{av[31]}}, av}) * $signed({{32{bv[31]}}, bv});
            {eh, el} = p;
        end else if (bv == 32'b0) begin
            eh = av;
            el = '1;
        end else if (o == OP_DIVU) begin
            el = av / bv;
            eh = av % bv;
        end else begin
            sa = longint'($signed(av));
            sb = longint'($signed(bv));
            q  = sa / sb;
            r  = sa % sb;
            el = q[31:0];
            eh = r[31:0];
        end
    endtask

    // Drive a request in the current cycle (called just after a rising edge)
    // and record its expected result on the scoreboard.
    task automatic applyStimulus(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv,
                                 input logic [31:0] eh, input logic [31:0] el);
        exp_t e;
        e.hi  = eh;
        e.lo  = el;
        e.tag = tag_cnt++;
        sb_q.push_back(e);
        start = 1'b1;
        op    = o;
        a     = av;
        b     = bv;
        @(posedge clk);
        #1;
        start   = 1'b0;
        hilo_we = 1'b0;
    endtask

    task automatic popCompare();
        logic [31:0] h, l;
        exp_t        e;
        readHiLo(h, l);
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL sb_empty actual=done required=no_done");
        end else begin
            e = sb_q.pop_front();
            check32($sformatf("hi_op%0d", e.tag), h, e.hi);
            check32($sformatf("lo_op%0d", e.tag), l, e.lo);
        end
    endtask

    // Follows a request cycle by cycle from cycle 1: busy must be high only in
    // cycles 1..LAT-1 and done must appear in cycle LAT.
    task automatic checkOutput();
        bit seen;
        bit busy_bad;
        seen     = 1'b0;
        busy_bad = 1'b0;
        for (int cyc = 1; cyc <= LAT + 6 && !seen; cyc++) begin
            @(negedge clk);
            if (busy !== (cyc < LAT)) busy_bad = 1'b1;
            if (done === 1'b1) begin
                seen = 1'b1;
                check32("done_cycle", cyc, LAT);
                popCompare();
            end
        end
        check32("busy_profile", {31'b0, busy_bad}, 32'd0);
        if (!seen) begin
            checks++;
            errors++;
            $display("[TB] FAIL done_timeout actual=no_done required=done");
            if (sb_q.size() != 0) void'(sb_q.pop_front());
        end
    endtask

    initial begin
        logic [31:0] h, l, eh, el, ra, rb;
        logic [1:0]  ro;
        bit          seen;
        int          dcount;

        checks    = 0;
        errors    = 0;
        tag_cnt   = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        op        = 2'b00;
        a         = '0;
        b         = '0;
        hilo_we   = 1'b0;
        hilo_wsel = 1'b0;
        wdata     = '0;
        rd_sel    = 1'b0;

        vecs[0] = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[1] = '{OP_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[2] = '{OP_DIVU,  32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003};
        vecs[3] = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[4] = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[5] = '{OP_DIVU,  32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF};
        vecs[6] = '{OP_DIV,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF};
        vecs[7] = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[8] = '{OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[9] = '{OP_DIVU,  32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF};

        // Reset state
        #2;
        check32("rst_busy", {31'b0, busy}, 32'd0);
        check32("rst_done", {31'b0, done}, 32'd0);
        readHiLo(h, l);
        check32("rst_hi", h, 32'd0);
        check32("rst_lo", l, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Vector table; each new request is issued in the previous done cycle
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo);
            checkOutput();
        end

        // MTLO / MTHI while idle
        @(posedge clk);
        #1;
        hilo_we = 1'b1; hilo_wsel = 1'b0; wdata = 32'h00001234;
        readHiLo(h, l);
        check32("mtlo_not_before_edge", l, 32'h0FFFFFFF);
        @(posedge clk);
        #1;
        hilo_wsel = 1'b1; wdata = 32'h00005678;
        @(posedge clk);
        #1;
        hilo_we = 1'b0;
        readHiLo(h, l);
        check32("mtlo_lo", l, 32'h00001234);
        check32("mthi_hi", h, 32'h00005678);

        // start and MTHI/MTLO while busy are ignored; HI/LO hold old values
        applyStimulus(OP_MULTU, 32'd3, 32'd4, 32'd0, 32'd12);
        seen = 1'b0;
        for (int cyc = 1; cyc <= LAT + 6 && !seen; cyc++) begin
            @(negedge clk);
            if (cyc == 10) begin start = 1'b1; op = OP_DIV; a = 32'd9; b = 32'd3; end
            if (cyc == 11) start = 1'b0;
            if (cyc == 12) begin hilo_we = 1'b1; hilo_wsel = 1'b0; wdata = 32'h0000DEAD; end
            if (cyc == 13) hilo_we = 1'b0;
            if (cyc == 20) begin
                readHiLo(h, l);
                check32("busy_hold_hi", h, 32'h00005678);
                check32("busy_hold_lo", l, 32'h00001234);
            end
            if (done === 1'b1) begin
                seen = 1'b1;
                check32("ignore_done_cycle", cyc, LAT);
                popCompare();
            end
        end
        if (!seen) begin
            checks++; errors++;
            $display("[TB] FAIL ignore_timeout actual=no_done required=done");
            if (sb_q.size() != 0) void'(sb_q.pop_front());
        end
        dcount = 0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            @(negedge clk);
            if (busy === 1'b1 || done === 1'b1) dcount++;
        end
        check32("no_relatch_activity", dcount, 0);
        @(posedge clk);
        #1;

        // MTHI in the same cycle as start: lands first, then overwritten
        hilo_we = 1'b1; hilo_wsel = 1'b1; wdata = 32'h0000AAAA;
        applyStimulus(OP_MULTU, 32'd2, 32'd2, 32'd0, 32'd4);
        readHiLo(h, l);
        check32("mthi_with_start", h, 32'h0000AAAA);
        checkOutput();

        // Reset in cycle 20 of an operation
        start = 1'b1; op = OP_MULTU; a = 32'd5; b = 32'd5;
        @(posedge clk);
        #1 start = 1'b0;
        for (int cyc = 1; cyc <= 20; cyc++) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check32("midrst_busy", {31'b0, busy}, 32'd0);
        readHiLo(h, l);
        check32("midrst_hi", h, 32'd0);
        check32("midrst_lo", l, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        dcount = 0;
        for (int cyc = 0; cyc < LAT + 4; cyc++) begin
            @(negedge clk);
            if (done === 1'b1) dcount++;
        end
        check32("midrst_no_done", dcount, 0);
        @(posedge clk);
        #1;
        applyStimulus(OP_MULTU, 32'd2, 32'd3, 32'd0, 32'd6);
        checkOutput();

        // Random operations against the reference model
        for (int i = 0; i < 6; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = (i == 5) ? 32'd0 : $urandom;
            if (i == 2) rb = rb >> 20;
            model(ro, ra, rb, eh, el);
            applyStimulus(ro, ra, rb, eh, el);
            checkOutput();
        end

        check32("sb_drained", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
